data_mem_stall: RTL and testbench

DATA_MEM_STALL -- requirements
Module: data_mem_stall

---
 rtl/data_mem_stall.sv | 114 +++++++++++
 tb/tb_data_mem_stall.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stall.sv
// data_mem_stall: word-addressed data memory with a fixed-latency, stalled access handshake.
// Latency: done pulses LATENCY cycles after accept; one access per LATENCY+1 cycles.
// Backpressure: stall is high while an access is in flight; requests are then ignored. HALT blocks accept. Optional macro DATA_MEM_ALIGN_CHECK_EN rejects odd addresses.
module data_mem_stall #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              MEM_WRITE,
  input  logic              MEM_READ,
  input  logic              HALT,
  output logic [DATA_W-1:0] read_data,
  output logic              done,
  output logic              stall,
  output logic              err
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic                  wr;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     dat;
  } req_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  req_t                  req_q;
  logic [DATA_W-1:0]     rd_hold_q;
  logic [DATA_W-1:0]     mem [WORDS];
  logic                  one_hot_req;
  logic                  both_req;
  logic                  misaligned;
  logic                  accept;
  logic                  unused_addr;

  assign one_hot_req = MEM_WRITE ^ MEM_READ;
  assign both_req    = MEM_WRITE & MEM_READ;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign misaligned = one_hot_req & addr[0];
`else
  assign misaligned = 1'b0;
`endif

  // Upper address bits wrap; bit 0 selects a byte within the word and is dropped.
  assign unused_addr = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    err     = 1'b0;
    case (state_q)
      IDLE: begin
        err = !rst && (both_req || misaligned);
        if (!rst && one_hot_req && !HALT && !misaligned) begin
          accept = 1'b1;
          if (LATENCY <= 1) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      rd_hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == DONE && !req_q.wr) rd_hold_q <= mem[req_q.idx];
    end
  end

  // Request payload needs no reset: it is only consumed in BUSY/DONE after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q.wr  <= MEM_WRITE;
      req_q.idx <= addr[DEPTH_LOG2:1];
      req_q.dat <= write_data;
    end
  end

  // Array is never reset; a reset in DONE suppresses the pending write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE && req_q.wr) mem[req_q.idx] <= req_q.dat;
  end

  assign done      = (state_q == DONE);
  assign stall     = (state_q != IDLE);
  assign read_data = (done && !req_q.wr) ? mem[req_q.idx] : rd_hold_q;

endmodule

// File: tb/tb_data_mem_stall.sv
// Bench for data_mem_stall: vector table through a request task, read results via a scoreboard queue,
// plus hand sequences for HALT/illegal requests mid-access and reset during BUSY.
module tb_data_mem_stall;

  localparam int LAT = 2;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic        halt;
  logic [15:0] read_data;
  logic        done;
  logic        stall;
  logic        err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] model_mem [int];
  logic [15:0] sb_q [$];
  logic [15:0] last_rd = 16'h0000;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        hlt;
    logic [15:0] a;
    logic [15:0] wd;
    logic        exp_err;
    logic        exp_acc;
  } vec_t;

  vec_t vecs [$];

  always #5 clk = ~clk;

  data_mem_stall #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(10), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .MEM_WRITE(mem_write), .MEM_READ(mem_read), .HALT(halt),
    .read_data(read_data), .done(done), .stall(stall), .err(err)
  );

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_idle();
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    halt       = 1'b0;
    addr       = 16'h0000;
    write_data = 16'h0000;
  endtask

  // Called just after the accept edge; returns on the negedge of the DONE cycle.
  task automatic wait_done(input logic is_rd, input string name);
    int cyc = 0;
    bit got = 0;
    logic [15:0] exp;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      check_bit({name, "_stall"}, stall, 1'b1);
      if (done === 1'b1) got = 1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected %0d", name, cyc, LAT);
    end else begin
      check_int({name, "_latency"}, cyc, LAT);
      if (is_rd) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s_sb: got read done with empty scoreboard, expected queued value", name);
        end else begin
          exp = sb_q.pop_front();
          check_word({name, "_rdata"}, read_data, exp);
          last_rd = exp;
        end
      end else begin
        check_word({name, "_rdata_hold"}, read_data, last_rd);
      end
    end
  endtask

  task automatic issue(input vec_t v, input int k);
    int idx;
    @(negedge clk);
    mem_write  = v.wr;
    mem_read   = v.rd;
    halt       = v.hlt;
    addr       = v.a;
    write_data = v.wd;
    #1;
    check_bit($sformatf("v%0d_err", k), err, v.exp_err);
    check_bit($sformatf("v%0d_idle_stall", k), stall, 1'b0);
    check_bit($sformatf("v%0d_idle_done", k), done, 1'b0);
    @(posedge clk);
    #1;
    set_idle();
    if (v.exp_acc) begin
      idx = int'(v.a[10:1]);
      if (v.wr) model_mem[idx] = v.wd;
      else      sb_q.push_back(model_mem[idx]);
      wait_done(v.rd, $sformatf("v%0d", k));
    end else begin
      check_bit($sformatf("v%0d_no_accept", k), stall, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit got;
    set_idle();
    rst = 1'b1;

    // Reset state; an illegal request while in reset must not raise err.
    @(posedge clk); #1;
    mem_write = 1'b1;
    mem_read  = 1'b1;
    #1;
    check_bit("rst_err", err, 1'b0);
    @(posedge clk); #1;
    check_bit("rst_stall", stall, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_word("rst_rdata", read_data, 16'h0000);
    set_idle();
    @(negedge clk);
    rst = 1'b0;

    //                wr    rd    hlt   addr      wdata     err    acc
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 16'h0800, 16'h5678, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b0});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 16'h0002, 16'hCAFE, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, ALIGN, !ALIGN});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 16'h07FE, 16'h0F0F, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 16'h07FE, 16'h0000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 16'h0006, 16'h1357, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 16'hF006, 16'h2468, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 16'h0004, 16'h1111, 1'b0, 1'b1});
    vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b1});

    for (int i = 0; i < vecs.size(); i++) issue(vecs[i], i);

    // HALT and an illegal request raised during an in-flight read: no abort, no err.
    @(negedge clk);
    mem_read = 1'b1;
    addr     = 16'h0000;
    #1;
    check_bit("halt_seq_accept_err", err, 1'b0);
    @(posedge clk); #1;
    halt       = 1'b1;
    mem_write  = 1'b1;
    write_data = 16'hDEAD;
    sb_q.push_back(model_mem[0]);
    cyc = 0;
    got = 0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      check_bit("halt_seq_err_quiet", err, 1'b0);
      check_bit("halt_seq_stall", stall, 1'b1);
      if (done === 1'b1) got = 1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL halt_seq_timeout: no done after %0d cycles, expected %0d", cyc, LAT);
    end else begin
      check_int("halt_seq_latency", cyc, LAT);
      check_word("halt_seq_rdata", read_data, sb_q.pop_front());
      last_rd = 16'h5678;
    end
    set_idle();
    issue(vec_t'{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1}, 100);

    // Reset while a write of 0xAAAA to 0x0004 is in BUSY: write is dropped.
    @(negedge clk);
    mem_write  = 1'b1;
    addr       = 16'h0004;
    write_data = 16'hAAAA;
    @(posedge clk); #1;
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    check_bit("rst_busy_stall", stall, 1'b1);
    check_bit("rst_busy_err", err, 1'b0);
    @(posedge clk); #1;
    check_bit("rst_abort_stall", stall, 1'b0);
    check_bit("rst_abort_done", done, 1'b0);
    check_word("rst_abort_rdata", read_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    last_rd = 16'h0000;
    @(negedge clk);
    check_bit("post_rst_stall", stall, 1'b0);
    check_word("post_rst_rdata", read_data, 16'h0000);
    issue(vec_t'{1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 1'b1}, 101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
